// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the RV32I control sequencer and the datapath muxes it steers.
// ISA header fallbacks so the slice elaborates stand-alone.
`ifndef ISA__OPCODE_WIDTH
`define ISA__OPCODE_WIDTH 7
`endif
`ifndef ISA__FUNCT3_WIDTH
`define ISA__FUNCT3_WIDTH 3
`endif
`ifndef ISA__OPCODE_LOAD
`define ISA__OPCODE_LOAD     7'b0000011
`define ISA__OPCODE_MISC_MEM 7'b0001111
`define ISA__OPCODE_OP_IMM   7'b0010011
`define ISA__OPCODE_AUIPC    7'b0010111
`define ISA__OPCODE_STORE    7'b0100011
`define ISA__OPCODE_OP       7'b0110011
`define ISA__OPCODE_LUI      7'b0110111
`define ISA__OPCODE_BRANCH   7'b1100011
`define ISA__OPCODE_JALR     7'b1100111
`define ISA__OPCODE_JAL      7'b1101111
`define ISA__OPCODE_SYSTEM   7'b1110011
`endif

package core_ctrl_pkg;

    localparam int unsigned OPCODE_W = `ISA__OPCODE_WIDTH;
    localparam int unsigned F3_W     = `ISA__FUNCT3_WIDTH;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned CAUSE_W  = 3;

    localparam logic [OPCODE_W-1:0] OPC_LOAD     = `ISA__OPCODE_LOAD;
    localparam logic [OPCODE_W-1:0] OPC_MISC_MEM = `ISA__OPCODE_MISC_MEM;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM   = `ISA__OPCODE_OP_IMM;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC    = `ISA__OPCODE_AUIPC;
    localparam logic [OPCODE_W-1:0] OPC_STORE    = `ISA__OPCODE_STORE;
    localparam logic [OPCODE_W-1:0] OPC_OP       = `ISA__OPCODE_OP;
    localparam logic [OPCODE_W-1:0] OPC_LUI      = `ISA__OPCODE_LUI;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH   = `ISA__OPCODE_BRANCH;
    localparam logic [OPCODE_W-1:0] OPC_JALR     = `ISA__OPCODE_JALR;
    localparam logic [OPCODE_W-1:0] OPC_JAL      = `ISA__OPCODE_JAL;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM   = `ISA__OPCODE_SYSTEM;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_MEM_WR = 3'd5,
        ST_PC_INC = 3'd6,
        ST_HALTED = 3'd7
    } state_e;

    typedef enum logic [SEL_W-1:0] {
        RD_SEL_ALU = 2'd0,
        RD_SEL_MEM = 2'd1,
        RD_SEL_PC4 = 2'd2,
        RD_SEL_CSR = 2'd3
    } rd_sel_e;

    typedef enum logic [SEL_W-1:0] {
        INSEL1_RS1  = 2'd0,
        INSEL1_PC   = 2'd1,
        INSEL1_ZERO = 2'd2
    } insel1_e;

    typedef enum logic [SEL_W-1:0] {
        INSEL2_RS2  = 2'd0,
        INSEL2_IMM  = 2'd1,
        INSEL2_FOUR = 2'd2
    } insel2_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_HALT_REQ = 3'd1,
        CAUSE_EBREAK   = 3'd2,
        CAUSE_STEP     = 3'd3,
        CAUSE_ILLEGAL  = 3'd4
    } halt_cause_e;

    // SYSTEM is split by funct3 into CSR access and environment call/break.
    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OP_IMM  = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_CSR     = 4'd9,
        CLS_ENV     = 4'd10,
        CLS_FENCE   = 4'd11,
        CLS_ILLEGAL = 4'd12
    } instr_class_e;

endpackage

// File: rtl/control_signals_if.sv
// Core control bundle: IR fields and memory completions in, datapath strobes and selects out.
interface control_signals_if;
    import core_ctrl_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic [F3_W-1:0]     f3;
    logic                mem_complete_read;
    logic                mem_complete_write;

    logic                store;
    logic                write_pc;
    logic                write_ir;
    logic                write_rd;
    logic                write_csr;
    logic                mem_read;
    logic                mem_write;
    logic                addr_sel;
    rd_sel_e             rd_sel;
    insel1_e             alu_insel1;
    insel2_e             alu_insel2;
    logic                halted;
    halt_cause_e         halt_cause;

    modport master (
        input  opcode, f3, mem_complete_read, mem_complete_write,
        output store, write_pc, write_ir, write_rd, write_csr,
        output mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
        output halted, halt_cause
    );

    modport slave (
        output opcode, f3, mem_complete_read, mem_complete_write,
        input  store, write_pc, write_ir, write_rd, write_csr,
        input  mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
        input  halted, halt_cause
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 classifier feeding the control sequencer.
module ctrl_decode
    import core_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [F3_W-1:0]     i_f3,
    output instr_class_e        o_cls
);

    always_comb begin
        o_cls = CLS_ILLEGAL;
        case (i_opcode)
            OPC_OP:       o_cls = CLS_OP;
            OPC_OP_IMM:   o_cls = CLS_OP_IMM;
            OPC_LUI:      o_cls = CLS_LUI;
            OPC_AUIPC:    o_cls = CLS_AUIPC;
            OPC_LOAD:     o_cls = CLS_LOAD;
            OPC_STORE:    o_cls = CLS_STORE;
            OPC_BRANCH:   o_cls = CLS_BRANCH;
            OPC_JAL:      o_cls = CLS_JAL;
            OPC_JALR:     o_cls = CLS_JALR;
            OPC_MISC_MEM: o_cls = CLS_FENCE;
            OPC_SYSTEM:   o_cls = (i_f3 == F3_W'(0)) ? CLS_ENV : CLS_CSR;
            default:      o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer with memory handshake and debug halt/resume/step.
module core_ctrl_fsm
    import core_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    control_signals_if.master ctrl
);

    state_e       r_state;
    state_e       w_state_nxt;
    instr_class_e r_cls;
    instr_class_e w_cls;
    instr_class_e w_cls_nxt;
    halt_cause_e  r_cause;
    halt_cause_e  w_cause_nxt;
    logic         r_step_pend;
    logic         w_step_pend_nxt;
    logic         w_instr_end;
    logic         w_cmpl_rd;
    logic         w_cmpl_wr;

    ctrl_decode u_decode (
        .i_opcode (ctrl.opcode),
        .i_f3     (ctrl.f3),
        .o_cls    (w_cls)
    );

    // Completions seen while reset is asserted must not fire Mealy strobes.
    assign w_cmpl_rd = ctrl.mem_complete_read  & rst_n;
    assign w_cmpl_wr = ctrl.mem_complete_write & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_cls       <= CLS_ILLEGAL;
            r_cause     <= CAUSE_NONE;
            r_step_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cls       <= w_cls_nxt;
            r_cause     <= w_cause_nxt;
            r_step_pend <= w_step_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cls_nxt       = r_cls;
        w_cause_nxt     = r_cause;
        w_step_pend_nxt = r_step_pend;
        w_instr_end     = 1'b0;
        ctrl.store      = 1'b0;
        ctrl.write_pc   = 1'b0;
        ctrl.write_ir   = 1'b0;
        ctrl.write_rd   = 1'b0;
        ctrl.write_csr  = 1'b0;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.addr_sel   = 1'b0;
        ctrl.rd_sel     = RD_SEL_ALU;
        ctrl.alu_insel1 = INSEL1_RS1;
        ctrl.alu_insel2 = INSEL2_RS2;
        ctrl.halted     = 1'b0;
        ctrl.halt_cause = r_cause;

        case (r_state)
            ST_BOOT: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_HALT_REQ;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (w_cmpl_rd) begin
                    ctrl.write_ir = 1'b1;
                    w_state_nxt   = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_cls_nxt   = w_cls;
                w_state_nxt = ST_EXEC;
            end

            ST_EXEC: begin
                case (r_cls)
                    CLS_OP, CLS_OP_IMM: begin
                        ctrl.write_rd   = 1'b1;
                        ctrl.alu_insel2 = (r_cls == CLS_OP) ? INSEL2_RS2 : INSEL2_IMM;
                        w_state_nxt     = ST_PC_INC;
                    end
                    CLS_LUI, CLS_AUIPC: begin
                        ctrl.write_rd   = 1'b1;
                        ctrl.alu_insel1 = (r_cls == CLS_LUI) ? INSEL1_ZERO : INSEL1_PC;
                        ctrl.alu_insel2 = INSEL2_IMM;
                        w_state_nxt     = ST_PC_INC;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.store      = 1'b1;
                        ctrl.alu_insel2 = INSEL2_IMM;
                        w_state_nxt     = (r_cls == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                    end
                    CLS_BRANCH: begin
                        if (branch_taken) begin
                            ctrl.write_pc   = 1'b1;
                            ctrl.alu_insel1 = INSEL1_PC;
                            ctrl.alu_insel2 = INSEL2_IMM;
                            w_instr_end     = 1'b1;
                        end else begin
                            w_state_nxt = ST_PC_INC;
                        end
                    end
                    CLS_JAL, CLS_JALR: begin
                        ctrl.write_pc   = 1'b1;
                        ctrl.write_rd   = 1'b1;
                        ctrl.rd_sel     = RD_SEL_PC4;
                        ctrl.alu_insel1 = (r_cls == CLS_JAL) ? INSEL1_PC : INSEL1_RS1;
                        ctrl.alu_insel2 = INSEL2_IMM;
                        w_instr_end     = 1'b1;
                    end
                    CLS_CSR: begin
                        ctrl.write_csr = 1'b1;
                        ctrl.write_rd  = 1'b1;
                        ctrl.rd_sel    = RD_SEL_CSR;
                        w_state_nxt    = ST_PC_INC;
                    end
                    CLS_ENV: begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = CAUSE_EBREAK;
                    end
                    CLS_FENCE: begin
                        w_state_nxt = ST_PC_INC;
                    end
                    default: begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end

            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.addr_sel = 1'b1;
                if (w_cmpl_rd) begin
                    ctrl.write_rd = 1'b1;
                    ctrl.rd_sel   = RD_SEL_MEM;
                    w_state_nxt   = ST_PC_INC;
                end
            end

            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.addr_sel  = 1'b1;
                if (w_cmpl_wr) begin
                    w_state_nxt = ST_PC_INC;
                end
            end

            ST_PC_INC: begin
                ctrl.write_pc   = 1'b1;
                ctrl.alu_insel1 = INSEL1_PC;
                ctrl.alu_insel2 = INSEL2_FOUR;
                w_instr_end     = 1'b1;
            end

            ST_HALTED: begin
                ctrl.halted = 1'b1;
                if (resume_req) begin
                    w_state_nxt     = ST_FETCH;
                    w_cause_nxt     = CAUSE_NONE;
                    w_step_pend_nxt = step_req;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        // Debug requests are only honoured between instructions; halt_req outranks a pending step.
        if (w_instr_end) begin
            w_step_pend_nxt = 1'b0;
            if (halt_req) begin
                w_state_nxt = ST_HALTED;
                w_cause_nxt = CAUSE_HALT_REQ;
            end else if (r_step_pend) begin
                w_state_nxt = ST_HALTED;
                w_cause_nxt = CAUSE_STEP;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end
    end

endmodule
